// File: rtl/uart_mmio_controller.sv
// uart_mmio_controller: MMIO window over the UART with a TX FIFO, paced launch FSM, RX capture and baud register.
// Defining UART_CTRL_RX_FIFO_EN swaps the single RX holding register for an RX_DEPTH FIFO.
module uart_mmio_controller #(
  parameter logic [31:0] DATA_ADDR   = 32'h10010000,
  parameter logic [31:0] STATUS_ADDR = 32'h10010005,
  parameter logic [31:0] BAUD_ADDR   = 32'h10010100,
  parameter int          TX_DEPTH    = 8,
  parameter int          RX_DEPTH    = 4,
  parameter logic [15:0] BAUD_RESET  = 16'h3,
  parameter int          ARM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        hit,
  output logic [7:0]  uart_data,
  output logic        uart_write_enable,
  input  logic        uart_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_out_valid,
  output logic [15:0] baud_max
);
  localparam int TW = $clog2(TX_DEPTH);
  localparam int TPW = TW + 1;
  localparam int CW = $clog2(ARM_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ARM, SEND} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [TW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [7:0] uart_data_q, uart_data_d;
  logic uart_write_enable_q, uart_write_enable_d;
  logic [15:0] baud_q, baud_d;
  logic ovr_q, ovr_d, ovf_q, ovf_d;
  logic sel_data, sel_status, sel_baud, data_wr, data_rd, stat_rd;
  logic tx_full, tx_empty, tx_push, launch, rx_valid, rx_ovr_set, unused_ok;
  logic [7:0] rx_head, status;

  assign sel_data   = address == DATA_ADDR;
  assign sel_status = address == STATUS_ADDR;
  assign sel_baud   = address == BAUD_ADDR;
  assign hit        = sel_data | sel_status | sel_baud;
  assign data_wr    = write_enable & sel_data;
  assign data_rd    = read_enable & sel_data;
  assign stat_rd    = read_enable & sel_status;
  assign tx_empty   = tx_wp_q == tx_rp_q;
  assign tx_full    = (tx_wp_q[TW] != tx_rp_q[TW]) && (tx_wp_q[TW-1:0] == tx_rp_q[TW-1:0]);
  // Fullness is judged before this cycle's launch pop, so a pop never frees room for a same-cycle push.
  assign tx_push    = data_wr & ~tx_full;
  assign launch     = (state_q == IDLE) & ~tx_empty & ~uart_busy;
  assign status     = {1'b0, uart_busy | (state_q != IDLE) | ~tx_empty, 1'b0, ovf_q, ovr_q, tx_empty, tx_full, rx_valid};
  assign read_data  = sel_data ? {24'b0, rx_head} : sel_status ? {24'b0, status} : sel_baud ? {16'b0, baud_q} : 32'b0;
  assign uart_data  = uart_data_q;
  assign uart_write_enable = uart_write_enable_q;
  assign baud_max   = baud_q;

  always_comb begin
    state_d = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      IDLE: if (launch) begin
        state_d = ARM;
        arm_cnt_d = '0;
      end
      ARM: if (uart_busy) state_d = SEND;
        else if (arm_cnt_q == CW'(ARM_TIMEOUT - 1)) state_d = IDLE;
        else arm_cnt_d = arm_cnt_q + 1'b1;
      SEND: if (!uart_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_wp_d = tx_wp_q + TPW'(tx_push);
    tx_rp_d = tx_rp_q + TPW'(launch);
    uart_data_d = launch ? tx_mem_q[tx_rp_q[TW-1:0]] : uart_data_q;
    uart_write_enable_d = launch;
    baud_d = (write_enable & sel_baud) ? write_data[15:0] : baud_q;
    ovf_d = (data_wr & tx_full) | (ovf_q & ~stat_rd);
    ovr_d = rx_ovr_set | (ovr_q & ~stat_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      arm_cnt_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      uart_data_q <= '0;
      uart_write_enable_q <= 1'b0;
      baud_q <= BAUD_RESET;
      ovr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_cnt_q <= arm_cnt_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      uart_data_q <= uart_data_d;
      uart_write_enable_q <= uart_write_enable_d;
      baud_q <= baud_d;
      ovr_q <= ovr_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[TW-1:0]] <= write_data[7:0];
  end

`ifdef UART_CTRL_RX_FIFO_EN
  localparam int RW = $clog2(RX_DEPTH);
  localparam int RPW = RW + 1;
  logic [7:0] rx_mem_q [RX_DEPTH];
  logic [RW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic rx_full, rx_push;
  assign rx_valid   = rx_wp_q != rx_rp_q;
  assign rx_full    = (rx_wp_q[RW] != rx_rp_q[RW]) && (rx_wp_q[RW-1:0] == rx_rp_q[RW-1:0]);
  assign rx_push    = uart_out_valid & ~rx_full;
  assign rx_ovr_set = uart_out_valid & rx_full;
  assign rx_head    = rx_valid ? rx_mem_q[rx_rp_q[RW-1:0]] : 8'h00;
  assign unused_ok  = ^write_data[31:16];
  always_comb begin
    rx_wp_d = rx_wp_q + RPW'(rx_push);
    rx_rp_d = rx_rp_q + RPW'(data_rd & rx_valid);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q[RW-1:0]] <= uart_rx_data;
  end
`else
  logic [7:0] rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d;
  assign rx_valid   = rx_valid_q;
  assign rx_head    = rx_valid_q ? rx_data_q : 8'h00;
  // A byte consumed by a same-cycle DATA read is not lost, so it does not count as an overrun.
  assign rx_ovr_set = uart_out_valid & rx_valid_q & ~data_rd;
  assign unused_ok  = ^{write_data[31:16], RX_DEPTH != 0};
  always_comb begin
    rx_data_d = uart_out_valid ? uart_rx_data : rx_data_q;
    rx_valid_d = uart_out_valid | (rx_valid_q & ~data_rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end
`endif
endmodule

// File: tb/tb_uart_mmio_controller.sv
// tb_uart_mmio_controller: queue-based model checked every cycle plus directed literal checks.
module tb_uart_mmio_controller;
  localparam logic [31:0] DA = 32'h10010000, SA = 32'h10010005, BA = 32'h10010100;
  localparam int TXD = 8, RXD = 4, TMO = 15;
  logic clk = 0, rst = 1;
  logic [31:0] address = 0, write_data = 0, read_data;
  logic write_enable = 0, read_enable = 0, hit, uart_write_enable, uart_busy = 0, uart_out_valid = 0;
  logic [7:0] uart_data, uart_rx_data = 0;
  logic [15:0] baud_max;
  int checks = 0, errors = 0;

  uart_mmio_controller dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
    .hit(hit), .uart_data(uart_data), .uart_write_enable(uart_write_enable),
    .uart_busy(uart_busy), .uart_rx_data(uart_rx_data), .uart_out_valid(uart_out_valid),
    .baud_max(baud_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte queues for both FIFOs, path phase 0 idle / 1 armed / 2 sending.
  logic [7:0] m_txq[$], m_rxq[$], dut_sent[$];
  int m_path = 0, m_arm = 0;
  logic m_uwe = 0, m_ovr = 0, m_ovf = 0, m_ok = 0;
  logic [7:0] m_udata = 0;
  logic [15:0] m_baud = 16'h3;
  logic dwr, drd, srd, lnch, txf, s_ovr, s_ovf;
  logic [31:0] exp_rd;

  function automatic logic [7:0] m_status();
    return {1'b0, uart_busy || m_path != 0 || m_txq.size() != 0, 1'b0, m_ovf, m_ovr,
            m_txq.size() == 0, m_txq.size() == TXD, m_rxq.size() != 0};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_path = 0; m_arm = 0; m_uwe = 0; m_udata = 0; m_baud = 16'h3; m_ovr = 0; m_ovf = 0; m_ok = 1;
    end else begin
      dwr = write_enable && address == DA;
      drd = read_enable && address == DA;
      srd = read_enable && address == SA;
      lnch = m_path == 0 && m_txq.size() != 0 && !uart_busy;
      txf = m_txq.size() == TXD;
      s_ovf = dwr && txf;
      if (lnch) begin m_path = 1; m_arm = 0; end
      else if (m_path == 1) begin
        m_arm++;
        if (uart_busy) m_path = 2;
        else if (m_arm >= TMO) m_path = 0;
      end else if (m_path == 2 && !uart_busy) m_path = 0;
      m_uwe = lnch;
      if (lnch) m_udata = m_txq.pop_front();
      if (dwr && !txf) m_txq.push_back(write_data[7:0]);
`ifdef UART_CTRL_RX_FIFO_EN
      s_ovr = uart_out_valid && m_rxq.size() == RXD;
      if (drd && m_rxq.size() != 0) void'(m_rxq.pop_front());
      if (uart_out_valid && !s_ovr) m_rxq.push_back(uart_rx_data);
`else
      s_ovr = uart_out_valid && m_rxq.size() != 0 && !drd;
      if (drd && m_rxq.size() != 0) void'(m_rxq.pop_front());
      if (uart_out_valid) begin m_rxq.delete(); m_rxq.push_back(uart_rx_data); end
`endif
      m_ovr = s_ovr || (m_ovr && !srd);
      m_ovf = s_ovf || (m_ovf && !srd);
      if (write_enable && address == BA) m_baud = write_data[15:0];
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      exp_rd = address == DA ? (m_rxq.size() != 0 ? {24'b0, m_rxq[0]} : 32'b0) :
               address == SA ? {24'b0, m_status()} : address == BA ? {16'b0, m_baud} : 32'b0;
      chk("m_uwe", uart_write_enable, m_uwe);
      chk("m_udata", uart_data, m_udata);
      chk("m_baud", baud_max, m_baud);
      chk("m_hit", hit, address == DA || address == SA || address == BA);
      chk("m_rdata", read_data, exp_rd);
      if (uart_write_enable) dut_sent.push_back(uart_data);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a; write_data = d; write_enable = 1;
    cyc();
    write_enable = 0; address = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    address = a; read_enable = 1;
    #2 d = read_data;
    cyc();
    read_enable = 0; address = 0;
  endtask

  task automatic wait_uwe(input string nm);
    int n = 0;
    while (!uart_write_enable && n < 30) begin cyc(); n++; end
    chk(nm, uart_write_enable, 1);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    repeat (2) cyc();
    rst = 0;
    // 1: reset state
    rd(SA, d);
    chk("t1_status", d, 32'h04);
    chk("t1_baud", baud_max, 16'h0003);
    chk("t1_uwe", uart_write_enable, 0);
    // 2: single byte latency and hold
    wr(DA, 32'h41);
    chk("t2_uwe_t1", uart_write_enable, 0);
    cyc();
    chk("t2_uwe_t2", uart_write_enable, 1);
    chk("t2_data", uart_data, 8'h41);
    cyc();
    chk("t2_uwe_t3", uart_write_enable, 0);
    uart_busy = 1;
    repeat (3) cyc();
    chk("t2_hold", uart_data, 8'h41);
    uart_busy = 0;
    repeat (3) cyc();
    // 3: overflow while UART busy, then in-order drain
    dut_sent.delete();
    uart_busy = 1;
    cyc();
    for (int i = 0; i < 9; i++) begin
      wr(DA, i);
      if (i == 7) begin
        address = SA; #1;
        chk("t3_full", read_data[1], 1);
        address = 0;
      end
    end
    rd(SA, d);
    chk("t3_status_ovf", d, 32'h52);
    rd(SA, d);
    chk("t3_status_clr", d, 32'h42);
    uart_busy = 0;
    for (int k = 0; k < 8; k++) begin
      wait_uwe("t3_launch");
      cyc();
      uart_busy = 1;
      repeat (2) cyc();
      uart_busy = 0;
    end
    repeat (20) cyc();
    chk("t3_count", dut_sent.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_order", dut_sent.size() > i ? {24'b0, dut_sent[i]} : 32'hFFFFFFFF, i);
    rd(SA, d);
    chk("t3_idle", d, 32'h04);
    // 4: two received bytes without a read
    uart_rx_data = 8'h55; uart_out_valid = 1;
    cyc();
    uart_rx_data = 8'hAA;
    cyc();
    uart_out_valid = 0;
    rd(SA, d);
`ifdef UART_CTRL_RX_FIFO_EN
    chk("t4_status", d, 32'h05);
    rd(DA, d);
    chk("t4_first", d, 32'h55);
    rd(DA, d);
    chk("t4_second", d, 32'hAA);
`else
    chk("t4_status", d, 32'h0D);
    rd(DA, d);
    chk("t4_last", d, 32'hAA);
`endif
    rd(SA, d);
    chk("t4_empty", d, 32'h04);
    // 5: baud register and decode
    address = BA; write_data = 32'h1234; write_enable = 1;
    #1 chk("t5_hit", hit, 1);
    cyc();
    write_enable = 0;
    chk("t5_baud", baud_max, 16'h1234);
    address = 32'h10010004;
    #1 chk("t5_nohit", hit, 0);
    chk("t5_nordata", read_data, 0);
    rd(BA, d);
    chk("t5_readback", d, 32'h1234);
    // 6: ARM timeout, then reset during SEND
    wr(DA, 32'h77);
    address = SA;
    wait_uwe("t6_launch");
    n = 0;
    while (read_data[6] && n < 40) begin n++; cyc(); end
    chk("t6_timeout", n, TMO);
    address = 0;
    dut_sent.delete();
    wr(DA, 32'h11);
    wait_uwe("t6_launch2");
    cyc();
    uart_busy = 1;
    wr(DA, 32'h22);
    wr(DA, 32'h33);
    rst = 1; uart_busy = 0;
    cyc();
    rst = 0;
    chk("t6_rst_uwe", uart_write_enable, 0);
    chk("t6_rst_data", uart_data, 0);
    rd(SA, d);
    chk("t6_rst_status", d, 32'h04);
    repeat (10) cyc();
    chk("t6_dropped", dut_sent.size(), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
